mem_dump_unit: RTL and testbench
================================

MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 Parameter ADDR_W, default 10, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data-memory word width; fixed at 32.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows:
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous active-high reset
REQ-004 start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-005 base_addr  input  ADDR_W  first word address, captured on an accepted start.
REQ-006 word_count  input  ADDR_W+1  number of words to dump (0..1024), captured on an accepted start.
REQ-007 mem_addr  output  ADDR_W  read address to the data-memory read port.
REQ-008 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_addr is presented (synchronous read).
REQ-009 out_data  output  8  byte stream data.
REQ-010 out_valid  output  1  byte valid.
REQ-011 out_ready  input  1  consumer ready; a transfer occurs when out_valid && out_ready.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse when a dump completes.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, WAIT, SEND and FIN.
REQ-015 In IDLE with start=1, the block SHALL capture base_addr and word_count: go to FIN if word_count=0, otherwise go to READ.
REQ-016 READ SHALL drive mem_addr=current address for one cycle, then go to WAIT.
REQ-017 In WAIT, the block SHALL latch mem_rdata into the shift register, set the byte index to 0, then go to SEND.
REQ-018 In SEND, out_valid=1 and out_data SHALL be byte[3-index] of the latched word (MSB first: bits 31:24, 23:16, 15:8, 7:0).
REQ-019 While out_valid=1 and out_ready=0, out_data SHALL remain stable and no state SHALL advance.
REQ-020 On each transfer, the byte index SHALL increment; on the fourth transfer, the remaining count SHALL decrement and the address SHALL increment.
REQ-021 After the fourth transfer, the FSM SHALL go to READ if remaining>0, else to FIN.
REQ-022 Address increment SHALL wrap modulo 2^ADDR_W (1023 -> 0).
REQ-023 FIN SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-024 The block SHALL ignore start whenever it is not in IDLE; the captured parameters SHALL be unaffected.
REQ-025 The best-case throughput SHALL be 6 cycles per word (READ, WAIT, 4×SEND) with out_ready held at 1.
REQ-026 out_valid SHALL be 0 in every state except SEND.
REQ-027 mem_addr SHALL hold the last driven address outside READ.

Reset
REQ-028 When rst=1, the FSM SHALL return to IDLE immediately, including mid-dump.
REQ-029 Reset values SHALL be: out_valid=0, out_data=0, busy=0, done=0, mem_addr=0, counters=0, shift register=0.
REQ-030 A reset taken mid-dump SHALL produce no done pulse and SHALL leave no partial byte pending.

Structure
REQ-031 A shared package SHALL hold ADDR_W, DATA_W, BYTES_PER_WORD=4, and the FSM state enum.
REQ-032 A single sub-module word_serializer SHALL contain the word load, byte index, and out_valid/out_ready handshake, and SHALL report last-byte-transferred to the FSM.
REQ-033 The FSM, address counter, and remaining counter SHALL reside in mem_dump_unit.

Verification
REQ-034 Scenario: base_addr=0x010, word_count=2, memory[0x010]=0x2B7E1516, memory[0x011]=0x28AED2A6, out_ready=1 -> bytes 2B 7E 15 16 28 AE D2 A6, done pulse 12 cycles after the READ of the first word, busy high throughout.
REQ-035 Scenario: word_count=0 -> no out_valid, done pulses one cycle after start, busy high for one cycle only.
REQ-036 Scenario: base_addr=0x3FF, word_count=2 -> mem_addr sequence 0x3FF then 0x000.
REQ-037 Scenario: out_ready toggled randomly (including held low 5 cycles mid-word) -> out_data stable while stalled, byte order unchanged, no bytes lost or duplicated.
REQ-038 Scenario: start pulsed again during SEND with different base_addr -> the second start is ignored and the original dump completes unchanged.
REQ-039 Scenario: rst asserted during SEND of word 1 of 3 -> out_valid=0 and busy=0 immediately, no done, and a new start afterwards dumps correctly from its own base_addr.

Source files
------------

// File: rtl/mem_dump_unit_pkg.sv
// Shared constants and FSM state encoding for the memory dump unit.
package mem_dump_unit_pkg;

    localparam int ADDR_W         = 10;
    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_dump_unit_word_serializer.sv
// Holds one memory word and streams it out MSB byte first over a
// valid/ready handshake; flags the transfer of the last byte.
module word_serializer (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load_i,
    input  logic [mem_dump_unit_pkg::DATA_W-1:0]  word_i,
    output logic [7:0]                            out_data_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic                                  last_xfer_o
);
    import mem_dump_unit_pkg::*;

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              xfer;

    assign xfer        = valid_q && out_ready_i;
    assign last_xfer_o = xfer && (idx_q == LAST_IDX);
    assign out_valid_o = valid_q;

    // Next word/index/valid: load in WAIT, step index per transfer, drop valid after last byte
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = word_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
            end
        end
    end

    // Byte select, most significant byte first
    always_comb begin
        out_data_o = word_q[31:24];
        case (idx_q)
            2'd0:    out_data_o = word_q[31:24];
            2'd1:    out_data_o = word_q[23:16];
            2'd2:    out_data_o = word_q[15:8];
            default: out_data_o = word_q[7:0];
        endcase
    end

    // Serializer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/mem_dump_unit.sv
// Dumps a block of data-memory words as an MSB-first byte stream.
// Sequencing FSM plus address and remaining-word counters; byte
// serialization lives in word_serializer.
module mem_dump_unit #(
    parameter int ADDR_W = mem_dump_unit_pkg::ADDR_W,
    parameter int DATA_W = mem_dump_unit_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    import mem_dump_unit_pkg::*;

    localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              load;
    logic              last_xfer;

    // Read address goes out live in READ and is held afterwards
    assign mem_addr = (state_q == ST_READ) ? addr_q : mem_addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);

    // Next-state and counter updates
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        mem_addr_d = mem_addr_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = word_count;
                    state_d  = (word_count == '0) ? ST_FIN : ST_READ;
                end
            end
            ST_READ: begin
                mem_addr_d = addr_q;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (last_xfer) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    state_d  = (remain_q == ONE_WORD) ? ST_FIN : ST_READ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            remain_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            remain_q   <= remain_d;
        end
    end

    word_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .word_i      (mem_rdata),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .last_xfer_o (last_xfer)
    );

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit with a synchronous-read memory model.
module tb_mem_dump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    mem_dump_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [9:0] addr_seen[$];
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = '0;
    int         stall_cnt  = 0;
    int         vcnt       = 0;
    int         done_cnt   = 0;
    int         st_cyc     = 0;

    // Observe stream mid-cycle: transfers, word starts, stall stability, pulses
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (out_valid && !prev_valid) addr_seen.push_back(mem_addr);
        if (prev_stall && out_valid) begin
            chk("stall_hold", {24'h0, out_data}, {24'h0, prev_data});
            stall_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_valid = out_valid;
        if (out_valid) vcnt++;
        if (done) done_cnt++;
    end

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        addr_seen.delete();
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_byte"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF,
                {24'h0, exp_q[i]});
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] w);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = w;
        st_cyc     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at, output int busy_lo);
        at      = -1;
        busy_lo = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) busy_lo++;
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    localparam logic [47:0] RDY_PAT = 48'hFFFF_FFFF_FD07;

    initial begin
        int at, bl, bh, v0, s0, d0;
        logic [47:0] pat;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_data", {24'h0, out_data}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_addr", {22'h0, mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-word dump, ready always high
        clear_obs();
        mem[10'h010] = 32'h2B7E1516;
        mem[10'h011] = 32'h28AED2A6;
        push_word(32'h2B7E1516);
        push_word(32'h28AED2A6);
        do_start(10'h010, 11'd2);
        wait_done(50, at, bl);
        chk("s1_latency", at - st_cyc, 32'd13);
        chk("s1_busy", bl, 32'd0);
        check_bytes("s1");
        @(negedge clk);
        chk("s1_done_once", {31'h0, done}, 32'd0);
        chk("s1_busy_after", {31'h0, busy}, 32'd0);

        // Zero words
        clear_obs();
        v0 = vcnt;
        do_start(10'h055, 11'd0);
        wait_done(10, at, bl);
        chk("s2_latency", at - st_cyc, 32'd1);
        chk("s2_busy_fin", bl, 32'd0);
        bh = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy) bh++;
        end
        chk("s2_busy_after", bh, 32'd0);
        chk("s2_no_valid", vcnt - v0, 32'd0);

        // Address wrap
        clear_obs();
        mem[10'h3FF] = 32'h01020304;
        mem[10'h000] = 32'hA5B6C7D8;
        push_word(32'h01020304);
        push_word(32'hA5B6C7D8);
        do_start(10'h3FF, 11'd2);
        wait_done(50, at, bl);
        chk("s3_nwords", addr_seen.size(), 32'd2);
        chk("s3_addr0", (addr_seen.size() > 0) ? {22'h0, addr_seen[0]} : 32'hFFFF_FFFF, 32'h3FF);
        chk("s3_addr1", (addr_seen.size() > 1) ? {22'h0, addr_seen[1]} : 32'hFFFF_FFFF, 32'h000);
        check_bytes("s3");
        @(negedge clk);
        chk("s3_addr_hold", {22'h0, mem_addr}, 32'h000);

        // Backpressure pattern with a 5-cycle stall mid-word
        clear_obs();
        mem[10'h100] = 32'h11223344;
        mem[10'h101] = 32'h55667788;
        push_word(32'h11223344);
        push_word(32'h55667788);
        s0  = stall_cnt;
        pat = RDY_PAT;
        do_start(10'h100, 11'd2);
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    out_ready = pat[i];
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            wait_done(80, at, bl);
        join
        chk("s4_latency", at - st_cyc, 32'd19);
        chk("s4_stalls", {31'h0, (stall_cnt - s0) == 6}, 32'd1);
        check_bytes("s4");

        // Second start during SEND is ignored
        clear_obs();
        mem[10'h020] = 32'hCAFEF00D;
        mem[10'h021] = 32'h0BADC0DE;
        mem[10'h180] = 32'hFFFFFFFF;
        push_word(32'hCAFEF00D);
        push_word(32'h0BADC0DE);
        do_start(10'h020, 11'd2);
        fork
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                start = 1'b1; base_addr = 10'h180; word_count = 11'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
            wait_done(50, at, bl);
        join
        chk("s5_latency", at - st_cyc, 32'd13);
        check_bytes("s5");
        repeat (3) @(negedge clk);
        chk("s5_idle_after", {31'h0, busy}, 32'd0);

        // Reset during SEND of the first of three words, then a fresh dump
        clear_obs();
        mem[10'h030] = 32'h10203040;
        mem[10'h031] = 32'h50607080;
        mem[10'h032] = 32'h90A0B0C0;
        mem[10'h040] = 32'hDEADBEEF;
        d0 = done_cnt;
        do_start(10'h030, 11'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("s6_pre_valid", {31'h0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("s6_rst_valid", {31'h0, out_valid}, 32'd0);
        chk("s6_rst_busy", {31'h0, busy}, 32'd0);
        chk("s6_rst_data", {24'h0, out_data}, 32'd0);
        chk("s6_rst_addr", {22'h0, mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("s6_no_done", done_cnt - d0, 32'd0);
        chk("s6_idle_valid", {31'h0, out_valid}, 32'd0);
        clear_obs();
        push_word(32'hDEADBEEF);
        do_start(10'h040, 11'd1);
        wait_done(30, at, bl);
        chk("s6_latency", at - st_cyc, 32'd7);
        check_bytes("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
